fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//   Read side of the byte FIFO: pops one word at a time and sends it on a serial
//   UART line (8N1 framing by default).
//   Connects directly to the FIFO's pop / is_empty / out ports. Used as the
//   console/debug TX path of the core: the CPU pushes into the FIFO, and this
//   block drains it.
// PARAMETERS
//   WIDTH         8   data bits per frame; must match the FIFO WIDTH
//   CLKS_PER_BIT  16  clk cycles per serial bit (start, data, stop); must be >= 2
// PORTS
//   clk            in   1      system clock, rising edge
//   rst_n          in   1      asynchronous reset, active low
//   enable         in   1      allows a new FIFO fetch; sampled only in IDLE
//   fifo_is_empty  in   1      FIFO empty flag
//   fifo_out       in   WIDTH  FIFO read data, registered, valid 1 cycle after the pop edge
//   fifo_pop       out  1      one-cycle pop strobe to the FIFO
//   tx             out  1      serial line; idles high
//   busy           out  1      high whenever state != IDLE
//   byte_done      out  1      one-cycle pulse after the stop bit completes
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - Outputs: tx=1, fifo_pop=0, busy=0, byte_done=0.
//     - Internal state: state=IDLE; shift reg, bit counter and baud counter = 0.
//   All outputs are registered.
//   FSM: IDLE -> POP -> WAIT -> START -> DATA -> STOP -> IDLE.
//     IDLE:  if enable && !fifo_is_empty at edge E0, go to POP with fifo_pop=1.
//            Otherwise stay in IDLE.
//     POP:   fifo_pop is high for exactly one cycle (E0..E1).
//            At E1: fifo_pop=0, go to WAIT (the FIFO updates its out at E1).
//     WAIT:  at E2: shreg<=fifo_out, tx<=0, baud_cnt<=0, go to START.
//     START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shreg[0].
//     DATA:  WIDTH bits, LSB first; each bit is held CLKS_PER_BIT cycles.
//            bit_cnt runs 0..WIDTH-1, with width $clog2(WIDTH), no wrap beyond.
//            After the last bit, go to STOP with tx=1.
//     STOP:  tx=1 for CLKS_PER_BIT cycles, then go to IDLE with byte_done=1
//            for one cycle.
//   Baud counter:
//     - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
//     - Only active in START/DATA/STOP.
//   Frame timing:
//     - Frame = (WIDTH+2)*CLKS_PER_BIT cycles, from the tx falling edge at E2.
//     - Back-to-back: next start bit begins exactly 3 cycles after the stop bit
//       ends (IDLE, POP and WAIT one cycle each).
//   Boundary conditions:
//     - enable deasserted mid-frame: current frame completes; no further pop.
//     - fifo_is_empty is ignored outside IDLE.
//     - At most one pop per frame; the FIFO never sees pop while it is empty.
//     - Reset mid-frame: tx returns to 1 immediately. The fetched word is
//       discarded (it is already popped and is not re-sent).
//     - fifo_out is only sampled at the WAIT->START edge. Changes at other
//       times are ignored.
// TESTING (WIDTH=8, CLKS_PER_BIT=4, FIFO model with registered out)
//   1. Hold rst_n=0 for 3 cycles, release, enable=1, FIFO empty for 20 cycles
//      -> tx=1, fifo_pop never high, busy=0.
//   2. Push 0xA5 -> fifo_pop high 1 cycle; tx low 2 cycles later.
//      -> tx then shows 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total),
//         followed by a byte_done pulse.
//   3. Push 0x00 then 0xFF -> two frames; exactly 3 idle-high cycles between
//      stop end and the 2nd start. Exactly 2 pops; FIFO empty afterwards.
//   4. Push 0x3C, 0x81; drop enable during the 1st frame's DATA
//      -> 0x3C is sent completely; 0x81 stays in the FIFO.
//      -> Re-raise enable -> 0x81 is sent.
//   5. Pulse rst_n low in the middle of DATA bit 4 -> tx=1 the same cycle,
//      busy=0. No byte_done. The next pushed byte is sent cleanly.
//   6. Bench checker samples tx at mid-bit, decodes each frame and compares
//      it to the push order. Assertions: fifo_pop never coincides with
//      fifo_is_empty=1, and fifo_pop is never high 2 cycles in a row.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between the byte FIFO and its UART drain.
// master = the UART TX block (issues pops), slave = the FIFO.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             fifo_pop;
  logic             fifo_is_empty;
  logic [WIDTH-1:0] fifo_out;

  modport master (output fifo_pop, input fifo_is_empty, fifo_out);
  modport slave  (input fifo_pop, output fifo_is_empty, fifo_out);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one word at a time onto an 8N1-style serial line.
// Every output is registered; the FSM's next-state logic precomputes them.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, sh_nxt;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic             tx_d, pop_q, pop_d, busy_d, done_d;

  assign sh_nxt        = shreg_q >> 1;
  assign fifo.fifo_pop = pop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_q     <= '0;
      baud_q    <= '0;
      tx        <= 1'b1;
      pop_q     <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      baud_q    <= baud_d;
      tx        <= tx_d;
      pop_q     <= pop_d;
      busy      <= busy_d;
      byte_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    tx_d    = tx;
    pop_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (enable && !fifo.fifo_is_empty) begin
          state_d = POP;
          pop_d   = 1'b1;
        end
      end
      // FIFO presents the popped word on the edge that leaves POP.
      POP: state_d = WAIT;
      WAIT: begin
        shreg_d = fifo.fifo_out;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      // shreg[0] always holds the bit currently on the line.
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = sh_nxt;
            tx_d    = sh_nxt[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (WIDTH=8, CLKS_PER_BIT=4) with a registered-out
// FIFO model, a mid-bit frame decoder and pop-protocol checks.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic tx, busy, byte_done;

  fifo_uart_tx_if #(.WIDTH(8)) fif ();

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo(fif),
    .tx(tx), .busy(busy), .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pop_cnt = 0;
  int t_done  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string nm);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read data, valid one cycle after the pop edge
  logic [7:0] mem [0:15];
  int wp = 0;
  int rp = 0;
  assign fif.fifo_is_empty = (wp == rp);
  always @(posedge clk) begin
    if (fif.fifo_pop && (wp != rp)) begin
      fif.fifo_out <= mem[rp & 15];
      rp <= rp + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wp & 15] = d;
    wp = wp + 1;
    exp_q.push_back(d);
  endtask

  // Pop protocol checks, sampled mid-cycle
  logic prev_pop = 1'b0;
  always @(negedge clk) begin
    prev_pop <= fif.fifo_pop;
    if (fif.fifo_pop === 1'b1) begin
      pop_cnt <= pop_cnt + 1;
      chk(fif.fifo_is_empty, 1'b0, "pop_while_empty");
      chk(prev_pop, 1'b0, "pop_two_cycles");
    end
  end

  // Independent line decoder: samples mid-bit, compares against push order
  logic       m_act = 1'b0;
  int         m_off = 0;
  logic [9:0] m_bits = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      if (tx == 1'b0) begin
        m_act <= 1'b1;
        m_off <= 0;
      end
    end else begin
      m_off <= m_off + 1;
      if ((m_off + 1) >= 2 && ((m_off + 1 - 2) % CPB) == 0) begin
        m_bits[(m_off + 1 - 2) / CPB] <= tx;
        if ((m_off + 1 - 2) / CPB == 9) begin
          m_act <= 1'b0;
          chk({m_bits[0], tx}, 2'b01, "mon_framing");
          if (exp_q.size() == 0) chk(32'd1, 32'd0, "mon_unexpected_frame");
          else chk(m_bits[8:1], exp_q.pop_front(), "mon_byte");
        end
      end
    end
  end

  // One frame: wait for pop, check 2-cycle start latency, then every bit mid-bit.
  task automatic run_frame(input logic [9:0] exp, input int drop_at, input bit b2b,
                           input string nm);
    int n;
    logic [9:0] got;
    logic busy_ok;
    n = 0;
    while (fif.fifo_pop !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk(fif.fifo_pop, 1'b1, {nm, "_pop_seen"});
    if (fif.fifo_pop !== 1'b1) return;
    @(negedge clk);
    chk({fif.fifo_pop, tx}, 2'b01, {nm, "_pop_one_cycle"});
    @(negedge clk);
    chk(tx, 1'b0, {nm, "_start_latency"});
    if (b2b) chk(cyc - t_done, 3, {nm, "_gap"});
    got = '0;
    busy_ok = busy;
    for (int off = 1; off <= 40; off++) begin
      @(negedge clk);
      if (off == drop_at) enable = 1'b0;
      if (off <= 38 && ((off - 2) % CPB) == 0) got[9 - (off - 2) / CPB] = tx;
      if (off < 40 && busy !== 1'b1) busy_ok = 1'b0;
    end
    chk(got, exp, {nm, "_line"});
    chk(busy_ok, 1'b1, {nm, "_busy_hold"});
    chk({byte_done, busy, tx}, 3'b101, {nm, "_done_pulse"});
    t_done = cyc;
    @(negedge clk);
    chk(byte_done, 1'b0, {nm, "_done_one_cycle"});
  endtask

  typedef struct {
    logic [7:0] d;
    int         npush;  // bytes pushed from this entry onward before the frame
    logic [9:0] exp;    // line bits in send order: start, d0..d7, stop
    bit         b2b;
  } vec_t;
  vec_t tbl [4];

  initial begin
    logic bad;
    int n;
    tbl[0] = '{d: 8'hA5, npush: 1, exp: 10'b0101001011, b2b: 1'b0};
    tbl[1] = '{d: 8'h00, npush: 2, exp: 10'b0000000001, b2b: 1'b0};
    tbl[2] = '{d: 8'hFF, npush: 0, exp: 10'b0111111111, b2b: 1'b1};
    tbl[3] = '{d: 8'h5A, npush: 1, exp: 10'b0010110101, b2b: 1'b0};

    // reset and idle with an empty FIFO
    repeat (3) @(negedge clk);
    chk({tx, fif.fifo_pop, busy, byte_done}, 4'b1000, "reset_outputs");
    rst_n  = 1'b1;
    enable = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fif.fifo_pop !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk(bad, 1'b0, "idle_empty");

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < tbl[i].npush; j++) push(tbl[i + j].d);
      run_frame(tbl[i].exp, -1, tbl[i].b2b, $sformatf("vec%0d", i));
    end
    chk(wp - rp, 0, "fifo_drained");

    // enable dropped during DATA: current frame completes, next word stays queued
    push(8'h3C);
    push(8'h81);
    run_frame(10'b0001111001, 12, 1'b0, "en_drop_3c");
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fif.fifo_pop !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk(bad, 1'b0, "en_low_no_pop");
    chk(wp - rp, 1, "en_low_word_kept");
    enable = 1'b1;
    run_frame(10'b0100000011, -1, 1'b0, "en_high_81");

    // reset in the middle of DATA bit 4
    push(8'hC3);
    n = 0;
    while (fif.fifo_pop !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk(fif.fifo_pop, 1'b1, "rst_pop_seen");
    repeat (2) @(negedge clk);
    chk(tx, 1'b0, "rst_start_seen");
    repeat (21) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tx, busy, fif.fifo_pop}, 3'b100, "rst_midframe_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    chk(bad, 1'b0, "rst_no_resend");
    chk(wp - rp, 0, "rst_word_discarded");
    push(8'h96);
    run_frame(10'b0011010011, -1, 1'b0, "post_rst_96");

    repeat (4) @(negedge clk);
    chk(exp_q.size(), 0, "all_frames_decoded");
    chk(pop_cnt, 8, "total_pops");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
